// File: rtl/alu_pkg.sv
// Shared definitions for the Alu sharing arbiter.
// Contents:
//   ALU_* constants : the six 4-bit Alu control codes the block will execute
//   state_t         : arbiter FSM states (IDLE, EXEC, RESP)
//   is_legal_ctr    : returns 1 when a control code is one of the six legal codes
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal_ctr(input logic [3:0] ctr);
        logic legal;
        case (ctr)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
            default:                                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters and the Alu sharing arbiter.
// Signals:
//   reqValid*/reqReady*  request handshake per port
//   reqCtr*/reqA*/reqB*  request payload per port (control code, operands)
//   respValid*/respReady* response handshake per port
//   respRes/respZero/respErr shared response payload, qualified by respValid0/1
// Modports: master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             reqValid0;
    logic             reqReady0;
    logic [3:0]       reqCtr0;
    logic [WIDTH-1:0] reqA0;
    logic [WIDTH-1:0] reqB0;
    logic             reqValid1;
    logic             reqReady1;
    logic [3:0]       reqCtr1;
    logic [WIDTH-1:0] reqA1;
    logic [WIDTH-1:0] reqB1;
    logic             respValid0;
    logic             respReady0;
    logic             respValid1;
    logic             respReady1;
    logic [WIDTH-1:0] respRes;
    logic             respZero;
    logic             respErr;

    modport master (
        output reqValid0, reqCtr0, reqA0, reqB0,
        output reqValid1, reqCtr1, reqA1, reqB1,
        output respReady0, respReady1,
        input  reqReady0, reqReady1,
        input  respValid0, respValid1, respRes, respZero, respErr
    );

    modport slave (
        input  reqValid0, reqCtr0, reqA0, reqB0,
        input  reqValid1, reqCtr1, reqA1, reqB1,
        input  respReady0, respReady1,
        output reqReady0, reqReady1,
        output respValid0, respValid1, respRes, respZero, respErr
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
// Ports: clk, rst_n; req0/req1 requests; en allows a grant this cycle;
//        gnt0/gnt1 one-hot (or zero) combinational grant.
// rr_last_r remembers the winner of the last tie; it resets to 1 so port 0
// wins the first tie. It only moves on a tie, single requests leave it alone.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic en,
    output logic gnt0,
    output logic gnt1
);
    logic rr_last_r;

    // grant selection: a tie goes to the port that did not win the last tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!en) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (req0 && req1) begin
            gnt0 = rr_last_r;
            gnt1 = ~rr_last_r;
        end else begin
            gnt0 = req0;
            gnt1 = req1 & ~req0;
        end
    end

    // tie-winner history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_r <= 1'b1;
        end else if (en && req0 && req1) begin
            rr_last_r <= gnt1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external 32-bit Alu between two requesters (port 0 = core execute
// path, port 1 = auxiliary unit) with round-robin arbitration.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   bus (slave)        request/response handshakes of both ports
//   aluIn1/aluIn2/aluCtr registered drive of the external Alu
//   aluRes/aluZero     external Alu outputs
//   busy               FSM not in IDLE
//   opCount            saturating count of completed legal operations
// Flow: IDLE grant -> EXEC (capture Alu result) -> RESP (hold until taken).
// Illegal control codes skip EXEC and answer directly with respErr=1.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_arbiter_if.slave bus,
    output logic [WIDTH-1:0] aluIn1,
    output logic [WIDTH-1:0] aluIn2,
    output logic [3:0]       aluCtr,
    input  logic [WIDTH-1:0] aluRes,
    input  logic             aluZero,
    output logic             busy,
    output logic [CNT_W-1:0] opCount
);
    state_t           state_r;
    logic             owner_r;
    logic [WIDTH-1:0] alu_in1_r;
    logic [WIDTH-1:0] alu_in2_r;
    logic [3:0]       alu_ctr_r;
    logic             resp_valid0_r;
    logic             resp_valid1_r;
    logic [WIDTH-1:0] resp_res_r;
    logic             resp_zero_r;
    logic             resp_err_r;
    logic [CNT_W-1:0] op_count_r;

    logic             en_s;
    logic             gnt0_s;
    logic             gnt1_s;
    logic [3:0]       sel_ctr_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;

    // grants only in IDLE and never while reset is held
    assign en_s = (state_r == IDLE) && rst_n;

    rr_arb2 u_rr_arb2 (
        .clk  (clk),
        .rst_n(rst_n),
        .req0 (bus.reqValid0),
        .req1 (bus.reqValid1),
        .en   (en_s),
        .gnt0 (gnt0_s),
        .gnt1 (gnt1_s)
    );

    // payload of the granted port
    always_comb begin
        sel_ctr_s = bus.reqCtr0;
        sel_a_s   = bus.reqA0;
        sel_b_s   = bus.reqB0;
        if (gnt1_s) begin
            sel_ctr_s = bus.reqCtr1;
            sel_a_s   = bus.reqA1;
            sel_b_s   = bus.reqB1;
        end else begin
            sel_ctr_s = bus.reqCtr0;
            sel_a_s   = bus.reqA0;
            sel_b_s   = bus.reqB0;
        end
    end

    // arbiter FSM with all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            owner_r       <= 1'b0;
            alu_in1_r     <= {WIDTH{1'b0}};
            alu_in2_r     <= {WIDTH{1'b0}};
            alu_ctr_r     <= 4'b0000;
            resp_valid0_r <= 1'b0;
            resp_valid1_r <= 1'b0;
            resp_res_r    <= {WIDTH{1'b0}};
            resp_zero_r   <= 1'b0;
            resp_err_r    <= 1'b0;
            op_count_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (gnt0_s || gnt1_s) begin
                        owner_r <= gnt1_s;
                        if (is_legal_ctr(sel_ctr_s)) begin
                            alu_in1_r <= sel_a_s;
                            alu_in2_r <= sel_b_s;
                            alu_ctr_r <= sel_ctr_s;
                            state_r   <= EXEC;
                        end else begin
                            // Alu inputs untouched so its output stays quiet
                            resp_res_r    <= {WIDTH{1'b0}};
                            resp_zero_r   <= 1'b0;
                            resp_err_r    <= 1'b1;
                            resp_valid0_r <= gnt0_s;
                            resp_valid1_r <= gnt1_s;
                            state_r       <= RESP;
                        end
                    end
                end
                EXEC: begin
                    resp_res_r <= aluRes;
                    resp_err_r <= 1'b0;
                    // the Alu zero output is only meaningful after sub/slt
                    if (alu_ctr_r == ALU_SUB || alu_ctr_r == ALU_SLT) begin
                        resp_zero_r <= aluZero;
                    end else begin
                        resp_zero_r <= (aluRes == {WIDTH{1'b0}});
                    end
                    if (op_count_r != {CNT_W{1'b1}}) begin
                        op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    resp_valid0_r <= ~owner_r;
                    resp_valid1_r <= owner_r;
                    state_r       <= RESP;
                end
                RESP: begin
                    if (owner_r ? bus.respReady1 : bus.respReady0) begin
                        resp_valid0_r <= 1'b0;
                        resp_valid1_r <= 1'b0;
                        state_r       <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.reqReady0  = gnt0_s;
    assign bus.reqReady1  = gnt1_s;
    assign bus.respValid0 = resp_valid0_r;
    assign bus.respValid1 = resp_valid1_r;
    assign bus.respRes    = resp_res_r;
    assign bus.respZero   = resp_zero_r;
    assign bus.respErr    = resp_err_r;
    assign aluIn1         = alu_in1_r;
    assign aluIn2         = alu_in2_r;
    assign aluCtr         = alu_ctr_r;
    assign busy           = (state_r != IDLE);
    assign opCount        = op_count_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural Alu.
// The DUT is built with CNT_W=4 so counter saturation is reachable quickly.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_ctr;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        busy;
    logic [3:0]  op_count;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter_if #(.WIDTH(32)) bus ();

    alu_share_arbiter #(.WIDTH(32), .CNT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .aluIn1 (alu_in1),
        .aluIn2 (alu_in2),
        .aluCtr (alu_ctr),
        .aluRes (alu_res),
        .aluZero(alu_zero),
        .busy   (busy),
        .opCount(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Alu model; zero is deliberately stale (1) for ops other than sub/slt
    always_comb begin
        case (alu_ctr)
            ALU_ADD: alu_res = alu_in1 + alu_in2;
            ALU_SUB: alu_res = alu_in1 - alu_in2;
            ALU_AND: alu_res = alu_in1 & alu_in2;
            ALU_OR:  alu_res = alu_in1 | alu_in2;
            ALU_SLT: alu_res = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
            ALU_NOR: alu_res = ~(alu_in1 | alu_in2);
            default: alu_res = 32'd0;
        endcase
        alu_zero = (alu_ctr == ALU_SUB || alu_ctr == ALU_SLT) ? (alu_res == 32'd0) : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present a request on port p, wait (bounded) for its grant, complete the edge
    task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic rdy;
        if (p == 0) begin
            bus.reqValid0 = 1'b1; bus.reqCtr0 = c; bus.reqA0 = a; bus.reqB0 = b;
        end else begin
            bus.reqValid1 = 1'b1; bus.reqCtr1 = c; bus.reqA1 = a; bus.reqB1 = b;
        end
        #1;
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rdy = (p == 0) ? bus.reqReady0 : bus.reqReady1;
            if (rdy) break;
            tick();
        end
        chk("grant_seen", 32'(rdy), 32'd1);
        tick();
        if (p == 0) bus.reqValid0 = 1'b0;
        else        bus.reqValid1 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.reqValid0 = 1'b1; bus.reqCtr0 = ALU_ADD; bus.reqA0 = 32'd5; bus.reqB0 = 32'd7;
        bus.reqValid1 = 1'b1; bus.reqCtr1 = ALU_SUB; bus.reqA1 = 32'd1; bus.reqB1 = 32'd1;
        bus.respReady0 = 1'b1;
        bus.respReady1 = 1'b1;

        // reset state with both ports requesting
        tick(); tick(); tick();
        chk("rst_reqReady0", 32'(bus.reqReady0), 32'd0);
        chk("rst_reqReady1", 32'(bus.reqReady1), 32'd0);
        chk("rst_respValid0", 32'(bus.respValid0), 32'd0);
        chk("rst_respValid1", 32'(bus.respValid1), 32'd0);
        chk("rst_opCount", 32'(op_count), 32'd0);
        chk("rst_aluCtr", 32'(alu_ctr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // release: port 0 wins the first tie
        rst_n = 1'b1;
        #1;
        chk("rel_reqReady0", 32'(bus.reqReady0), 32'd1);
        chk("rel_reqReady1", 32'(bus.reqReady1), 32'd0);
        bus.reqValid1 = 1'b0;

        // single add: 5 + 7
        tick();
        bus.reqValid0 = 1'b0;
        chk("add_exec_busy", 32'(busy), 32'd1);
        chk("add_aluIn1", alu_in1, 32'd5);
        chk("add_aluIn2", alu_in2, 32'd7);
        chk("add_aluCtr", 32'(alu_ctr), 32'(ALU_ADD));
        chk("add_respValid0_early", 32'(bus.respValid0), 32'd0);
        tick();
        chk("add_respValid0", 32'(bus.respValid0), 32'd1);
        chk("add_respValid1", 32'(bus.respValid1), 32'd0);
        chk("add_respRes", bus.respRes, 32'd12);
        chk("add_respZero", 32'(bus.respZero), 32'd0);
        chk("add_respErr", 32'(bus.respErr), 32'd0);
        chk("add_opCount", 32'(op_count), 32'd1);
        tick();
        chk("add_done_valid", 32'(bus.respValid0), 32'd0);
        chk("add_done_busy", 32'(busy), 32'd0);

        // sub 9-9 with backpressure; a port 1 request must not be granted meanwhile
        bus.respReady0 = 1'b0;
        issue(0, ALU_SUB, 32'd9, 32'd9);
        tick();
        chk("sub_respRes", bus.respRes, 32'd0);
        chk("sub_respZero", 32'(bus.respZero), 32'd1);
        bus.reqValid1 = 1'b1; bus.reqCtr1 = ALU_ADD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_respValid0", 32'(bus.respValid0), 32'd1);
            chk("bp_respRes", bus.respRes, 32'd0);
            chk("bp_respZero", 32'(bus.respZero), 32'd1);
            chk("bp_reqReady1", 32'(bus.reqReady1), 32'd0);
        end
        bus.reqValid1 = 1'b0;
        bus.respReady0 = 1'b1;
        tick();
        chk("sub_released", 32'(bus.respValid0), 32'd0);

        // slt 3 < 8
        issue(0, ALU_SLT, 32'd3, 32'd8);
        tick();
        chk("slt_respRes", bus.respRes, 32'd1);
        chk("slt_respZero", 32'(bus.respZero), 32'd0);
        chk("slt_opCount", 32'(op_count), 32'd3);
        tick();

        // contention: both ports continuously valid -> 0,1,0,1
        bus.reqValid0 = 1'b1; bus.reqCtr0 = ALU_ADD; bus.reqA0 = 32'd1;   bus.reqB0 = 32'd2;
        bus.reqValid1 = 1'b1; bus.reqCtr1 = ALU_OR;  bus.reqA1 = 32'hF0;  bus.reqB1 = 32'h0F;
        #1;
        for (int n = 0; n < 4; n++) begin
            chk("rr_reqReady0", 32'(bus.reqReady0), (n % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_reqReady1", 32'(bus.reqReady1), (n % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("rr_exec_v0", 32'(bus.respValid0), 32'd0);
            chk("rr_exec_v1", 32'(bus.respValid1), 32'd0);
            tick();
            chk("rr_resp_v0", 32'(bus.respValid0), (n % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_resp_v1", 32'(bus.respValid1), (n % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_respRes", bus.respRes, (n % 2 == 0) ? 32'd3 : 32'hFF);
            tick();
        end
        bus.reqValid0 = 1'b0;
        bus.reqValid1 = 1'b0;
        chk("rr_opCount", 32'(op_count), 32'd7);

        // illegal code on port 1: answered one edge after the grant
        issue(1, 4'b1111, 32'd123, 32'd456);
        chk("ill_respValid1", 32'(bus.respValid1), 32'd1);
        chk("ill_respValid0", 32'(bus.respValid0), 32'd0);
        chk("ill_respErr", 32'(bus.respErr), 32'd1);
        chk("ill_respRes", bus.respRes, 32'd0);
        chk("ill_respZero", 32'(bus.respZero), 32'd0);
        chk("ill_aluIn1", alu_in1, 32'hF0);
        chk("ill_aluIn2", alu_in2, 32'h0F);
        chk("ill_aluCtr", 32'(alu_ctr), 32'(ALU_OR));
        chk("ill_opCount", 32'(op_count), 32'd7);
        tick();
        chk("ill_done", 32'(bus.respValid1), 32'd0);

        // reset during EXEC drops the operation
        issue(0, ALU_ADD, 32'd10, 32'd20);
        chk("rexec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rexec_busy_rst", 32'(busy), 32'd0);
        chk("rexec_opCount", 32'(op_count), 32'd0);
        chk("rexec_aluIn1", alu_in1, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rexec_respValid0", 32'(bus.respValid0), 32'd0);
            chk("rexec_idle", 32'(busy), 32'd0);
        end

        // 20 operations: 4-bit counter saturates at 15
        for (int i = 1; i <= 20; i++) begin
            issue(0, ALU_ADD, 32'(i), 32'(i));
            tick();
            chk("sat_respRes", bus.respRes, 32'(2 * i));
            chk("sat_respErr", 32'(bus.respErr), 32'd0);
            chk("sat_opCount", 32'(op_count), (i < 15) ? 32'(i) : 32'd15);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
